alu_share_arbiter: RTL and testbench

- Shares one combinational ALU between two requesters (port 0, port 1) using round-robin arbitration.
- Each requester presents operands and an operation select with a valid/ready handshake.
- The block latches the winning request, drives the ALU for one cycle, registers the result, carry-out and zero flag, and holds the response until the owner accepts it.
- Sits between the ALU and its two clients (e.g. address-generation logic and execute stage).

---
 rtl/alu_share_arbiter.sv | 133 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two requesters; accept at T, response valid at T+2.
// Only one operation is in flight; requesters see no ready until the response handshake for the current owner.
module alu_share_arbiter #(
  parameter int WIDTH   = 32,
  parameter int SELW    = 4,
  parameter int MAX_SEL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [SELW-1:0]  req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [SELW-1:0]  req1_sel,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_cout,
  output logic             resp_z,
  output logic             resp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SELW-1:0]  alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_cout,
  input  logic             alu_z
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [SELW-1:0] MAX_SEL_W = SELW'(MAX_SEL);

  state_t state;
  state_t state_nxt;
  logic   prio;
  logic   owner;
  logic   gnt;
  logic   gnt_vld;
  logic   resp_hs;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    gnt         = 1'b0;
    gnt_vld     = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    resp_hs     = 1'b0;
    case (state)
      IDLE: begin
        // Reset must block the accept so nothing is latched in that cycle.
        gnt_vld = !rst && (req0_valid || req1_valid);
        gnt     = (req0_valid && req1_valid) ? prio : req1_valid;
        if (gnt_vld) begin
          req0_ready = !gnt;
          req1_ready = gnt;
          state_nxt  = ISSUE;
        end
      end
      ISSUE: begin
        state_nxt = RESP;
      end
      RESP: begin
        resp0_valid = !owner;
        resp1_valid = owner;
        resp_hs     = owner ? resp1_ready : resp0_ready;
        if (resp_hs) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio      <= 1'b0;
      owner     <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      resp_data <= '0;
      resp_cout <= 1'b0;
      resp_z    <= 1'b0;
      resp_err  <= 1'b0;
    end else begin
      if (gnt_vld) begin
        owner   <= gnt;
        alu_a   <= gnt ? req1_a : req0_a;
        alu_b   <= gnt ? req1_b : req0_b;
        alu_sel <= gnt ? req1_sel : req0_sel;
      end
      // Illegal selects still reach the ALU; only the error flag records them.
      if (state == ISSUE) begin
        resp_data <= alu_out;
        resp_cout <= alu_cout;
        resp_z    <= alu_z;
        resp_err  <= (alu_sel > MAX_SEL_W);
      end
      if (resp_hs) begin
        prio <= ~owner;
      end
    end
  end

  a_one_ready: assert property (@(posedge clk) disable iff (rst) !(req0_ready && req1_ready));
  a_one_resp:  assert property (@(posedge clk) disable iff (rst) !(resp0_valid && resp1_valid));
  a_ready_idle: assert property (@(posedge clk) disable iff (rst)
                                 (req0_ready || req1_ready) |-> (state == IDLE));

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomised and directed bench for alu_share_arbiter with a queue-based scoreboard and an ALU model.
module tb_alu_share_arbiter;

  typedef struct packed {
    logic [31:0] data;
    logic        cout;
    logic        z;
    logic        err;
  } res_t;

  typedef struct {
    int   port;
    res_t r;
    int   cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_sel, req1_sel;
  logic        resp0_valid, resp1_valid;
  logic        resp0_ready, resp1_ready;
  logic [31:0] resp_data;
  logic        resp_cout, resp_z, resp_err;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_sel;
  logic        alu_cout, alu_z;
  res_t        alu_r;

  int checks   = 0;
  int failures = 0;

  // Scoreboard / model state, owned by the monitor
  exp_t exp_q[$];
  int   grant_log[$];
  int   cyc = 0;
  bit   busy = 0;
  bit   resp_act = 0;
  bit   prio_m = 0;
  res_t hold_r;
  int   hold_port;
  int   resp_len;
  res_t last_res;
  int   last_port;
  int   last_len[2];
  int   last_acc[2];
  int   last_hs[2];
  bit   rnd_done;

  alu_share_arbiter #(.WIDTH(32), .SELW(4), .MAX_SEL(2)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_data(resp_data), .resp_cout(resp_cout), .resp_z(resp_z), .resp_err(resp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_cout(alu_cout), .alu_z(alu_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arithmetic meaning of each select code; illegal codes yield zero.
  function automatic res_t ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel);
    res_t        r;
    logic [32:0] s;
    r = '0;
    s = {1'b0, a} + {1'b0, b};
    case (sel)
      4'd0: r.data = a & b;
      4'd1: r.data = a | b;
      4'd2: begin r.data = s[31:0]; r.cout = s[32]; end
      default: r.err = 1'b1;
    endcase
    r.z = (r.data == 32'd0);
    return r;
  endfunction

  always_comb alu_r = ref_alu(alu_a, alu_b, alu_sel);
  assign alu_out  = alu_r.data;
  assign alu_cout = alu_r.cout;
  assign alu_z    = alu_r.z;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: arbitration model, scoreboard pop, latency and stability
  always @(negedge clk) begin
    int   g;
    int   p;
    int   exp_g;
    exp_t e;
    cyc++;
    if (rst) begin
      exp_q.delete();
      busy     = 0;
      resp_act = 0;
      prio_m   = 0;
    end else begin
      if (req0_ready && req1_ready) check("dual_ready", 1, 0);
      if (req0_ready || req1_ready) begin
        g = req1_ready ? 1 : 0;
        check("ready_needs_valid", g ? req1_valid : req0_valid, 1);
        check("ready_while_busy", busy, 0);
        exp_g = req1_valid ? ((req0_valid) ? int'(prio_m) : 1) : 0;
        check("grant_port", g, exp_g);
        e.port = g;
        e.r    = g ? ref_alu(req1_a, req1_b, req1_sel) : ref_alu(req0_a, req0_b, req0_sel);
        e.cyc  = cyc;
        exp_q.push_back(e);
        grant_log.push_back(g);
        last_acc[g] = cyc;
        busy = 1;
      end
      if (resp0_valid && resp1_valid) check("dual_resp_valid", 1, 0);
      if (resp0_valid || resp1_valid) begin
        p = resp1_valid ? 1 : 0;
        if (!resp_act) begin
          if (exp_q.size() == 0) begin
            check("spurious_resp", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("resp_port", p, e.port);
            check("resp_data", resp_data, e.r.data);
            check("resp_cout", resp_cout, e.r.cout);
            check("resp_z", resp_z, e.r.z);
            check("resp_err", resp_err, e.r.err);
            check("resp_latency", cyc - e.cyc, 2);
            hold_r    = {resp_data, resp_cout, resp_z, resp_err};
            hold_port = p;
            resp_len  = 0;
            resp_act  = 1;
          end
        end else begin
          check("resp_stable_port", p, hold_port);
          check("resp_stable_dat", {resp_data, resp_cout, resp_z, resp_err}, hold_r);
        end
        resp_len++;
        if (p ? resp1_ready : resp0_ready) begin
          last_res    = {resp_data, resp_cout, resp_z, resp_err};
          last_port   = p;
          last_len[p] = resp_len;
          last_hs[p]  = cyc;
          resp_act    = 0;
          busy        = 0;
          prio_m      = !p;
        end
      end else if (resp_act) begin
        check("resp_dropped_early", 1, 0);
        resp_act = 0;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept with valid dropped.
  task automatic drive_req(input int p, input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel);
    int n = 0;
    if (p == 0) begin req0_valid = 1; req0_a = a; req0_b = b; req0_sel = sel; end
    else        begin req1_valid = 1; req1_a = a; req1_b = b; req1_sel = sel; end
    forever begin
      @(negedge clk);
      if ((p == 0) ? req0_ready : req1_ready) break;
      n++;
      if (n > 300) begin
        check($sformatf("req%0d_accept_timeout", p), 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
    if (p == 0) req0_valid = 0; else req1_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    forever begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0 && !resp0_valid && !resp1_valid) break;
      n++;
      if (n > 300) begin
        check("idle_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_alu_a"}, alu_a, 0);
    check({tag, "_alu_b"}, alu_b, 0);
    check({tag, "_alu_sel"}, alu_sel, 0);
    check({tag, "_resp_data"}, resp_data, 0);
    check({tag, "_resp_flags"}, {resp_cout, resp_z, resp_err}, 0);
    check({tag, "_resp_valids"}, {resp0_valid, resp1_valid}, 0);
    check({tag, "_req_readys"}, {req0_ready, req1_ready}, 0);
  endtask

  task automatic port_loop(input int p, input int nops);
    logic [31:0] a, b;
    logic [3:0]  sel;
    int          k;
    repeat (nops) begin
      k = $urandom % 3;
      repeat (k) begin @(posedge clk); #1; end
      sel = ($urandom % 8 == 0) ? 4'($urandom_range(3, 15)) : 4'($urandom % 3);
      a   = ($urandom % 6 == 0) ? 32'hFFFF_FFFF : $urandom;
      b   = ($urandom % 6 == 0) ? 32'h0000_0001 : $urandom;
      drive_req(p, a, b, sel);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1; req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req0_sel = 0; req1_a = 0; req1_b = 0; req1_sel = 0;
    resp0_ready = 0; resp1_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;

    // Single OR on port 0
    resp0_ready = 1;
    drive_req(0, 32'h0000_00F0, 32'h0000_0F0F, 4'd1);
    wait_idle();
    check("or_port", last_port, 0);
    check("or_data", last_res.data, 32'h0000_0FFF);
    check("or_flags", {last_res.z, last_res.err}, 2'b00);

    // ADD with carry and zero on port 1, ready tied high
    resp1_ready = 1;
    drive_req(1, 32'hFFFF_FFFF, 32'h0000_0001, 4'd2);
    wait_idle();
    check("add_port", last_port, 1);
    check("add_data", last_res.data, 32'h0);
    check("add_cout_z", {last_res.cout, last_res.z}, 2'b11);
    check("add_valid_len", last_len[1], 1);

    // Contention: both continuously valid, AND
    grant_log.delete();
    fork
      repeat (3) drive_req(0, $urandom, $urandom, 4'd0);
      repeat (3) drive_req(1, $urandom, $urandom, 4'd0);
    join
    wait_idle();
    check("contend_count", grant_log.size(), 6);
    for (int i = 0; i < grant_log.size(); i++) check($sformatf("contend_grant%0d", i), grant_log[i], i % 2);

    // Backpressure on port 0 while port 1 waits
    resp0_ready = 0;
    fork drive_req(0, 32'h1234_5678, 32'h0F0F_0F0F, 4'd2); join_none
    n = 0;
    do begin @(negedge clk); n++; end while (!resp0_valid && n < 50);
    check("bp_resp_seen", resp0_valid, 1);
    @(posedge clk); #1;
    fork drive_req(1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 4'd1); join_none
    repeat (4) @(posedge clk);
    #1 resp0_ready = 1;
    wait_idle();
    check("bp_hold_len", last_len[0], 6);
    check("bp_accept_gap", last_acc[1] - last_hs[0], 1);

    // Illegal select
    drive_req(0, 32'd5, 32'd3, 4'hA);
    wait_idle();
    check("illegal_err", last_res.err, 1);
    check("illegal_data", last_res.data, 0);
    check("illegal_z", last_res.z, 1);

    // Reset in the ISSUE cycle
    fork drive_req(0, 32'd7, 32'd9, 4'd2); join_none
    n = 0;
    do begin @(negedge clk); n++; end while (!req0_ready && n < 50);
    check("midrst_accept_seen", req0_ready, 1);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check_zero("midrst");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("midrst_no_resp%0d", i), {resp0_valid, resp1_valid}, 0);
    end
    @(posedge clk); #1;
    grant_log.delete();
    fork
      drive_req(0, 32'd11, 32'd4, 4'd2);
      drive_req(1, 32'd12, 32'd4, 4'd2);
    join
    wait_idle();
    check("midrst_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

    // Random traffic with random response backpressure
    rnd_done = 0;
    fork
      begin
        fork
          port_loop(0, 40);
          port_loop(1, 40);
        join
        rnd_done = 1;
      end
      while (!rnd_done) begin
        @(posedge clk); #1;
        resp0_ready = 1'($urandom % 2);
        resp1_ready = 1'($urandom % 2);
      end
    join
    resp0_ready = 1; resp1_ready = 1;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
